wb_reg_slice: RTL and testbench
===============================

Name: wb_reg_slice

Overview:
Registered Wishbone B3 slice between the tile memory port and the Wishbone-to-NASTI DDR bridge. It breaks the combinational ack/data path between the tile and the bridge for timing closure, and flattens bursts into single classic beats. A response timeout guarantees the tile never hangs on a stalled DDR path.

Parameters:
ADDR_WIDTH, 28, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; SEL width = DATA_WIDTH/8
TIMEOUT, 1024, cycles in REQ before forced error; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wbs_cyc_i  in  1  upstream cycle
wbs_stb_i  in  1  upstream strobe
wbs_we_i  in  1  upstream write enable
wbs_adr_i  in  ADDR_WIDTH  upstream address
wbs_dat_i  in  DATA_WIDTH  upstream write data
wbs_sel_i  in  DATA_WIDTH/8  upstream byte select
wbs_cti_i  in  3  upstream cycle type (accepted, not forwarded)
wbs_bte_i  in  2  upstream burst type (accepted, not forwarded)
wbs_ack_o  out  1  upstream ack
wbs_err_o  out  1  upstream error
wbs_rty_o  out  1  upstream retry
wbs_dat_o  out  DATA_WIDTH  upstream read data
wbm_cyc_o  out  1  downstream cycle
wbm_stb_o  out  1  downstream strobe
wbm_we_o  out  1  downstream write enable
wbm_adr_o  out  ADDR_WIDTH  downstream address
wbm_dat_o  out  DATA_WIDTH  downstream write data
wbm_sel_o  out  DATA_WIDTH/8  downstream byte select
wbm_cti_o  out  3  always 3'b111
wbm_bte_o  out  2  always 2'b00
wbm_ack_i  in  1  downstream ack
wbm_err_i  in  1  downstream error
wbm_rty_i  in  1  downstream retry
wbm_dat_i  in  DATA_WIDTH  downstream read data

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 except wbm_cti_o=3'b111; timeout counter 0; abort flag 0.
- All outputs are registered; no combinational path from any input to any output.
- IDLE: on wbs_cyc_i&wbs_stb_i, capture we/adr/dat/sel, set wbm_cyc_o=wbm_stb_o=1 next edge, go REQ.
- REQ: hold request stable. First cycle with wbm_ack_i|wbm_err_i|wbm_rty_i: capture wbm_dat_i (reads only; hold old value on writes) and the response type (priority err > rty > ack when several are set), drop wbm_cyc_o/wbm_stb_o, go RSP. Counter increments each REQ cycle. At count==TIMEOUT-1 with no response (TIMEOUT!=0): drop wbm_cyc/stb, set err, go RSP.
- RSP: assert exactly one of wbs_ack_o/err_o/rty_o for one cycle with wbs_dat_o valid, then go IDLE. A back-to-back beat is sampled in the IDLE cycle that follows.
- Latency: request at upstream cycle 0 -> wbm_stb_o at 1 -> downstream response at k -> upstream response at k+1. Minimum 3 cycles per beat; the next beat issues 2 cycles after the upstream ack.
- Bursts: each beat is forwarded as a classic single access. Upstream cti/bte are ignored; address increment is the upstream master's job.
- Upstream abort (wbs_cyc_i low in REQ): the downstream access completes normally. Its response is discarded (abort flag set, no upstream strobe in RSP). The flag clears on entering IDLE.
- Counter clears on leaving REQ. A response on the same cycle as the timeout wins over the timeout.
- Downstream responses outside REQ are ignored.
- rst asserted mid-transaction: immediate IDLE, wbm_cyc_o drops asynchronously.

Test Plan:
- Single read adr=0x0000100: downstream acks 2 cycles after wbm_stb_o with 0xDEADBEEF -> wbs_ack_o one cycle later with wbs_dat_o=0xDEADBEEF; upstream cycle-0-to-ack latency = 4.
- Write adr=0x0000200, dat=0x12345678, sel=4'b0011 -> wbm_we_o=1 and the same adr/dat/sel on downstream; one wbs_ack_o pulse; wbm_cti_o=3'b111.
- 4-beat incrementing burst (cti=010, final beat 111) from 0x0000400 -> four downstream classic accesses at 0x400/0x404/0x408/0x40C; four upstream acks; wbm_cyc_o low between beats.
- TIMEOUT=16 with downstream never acking -> wbm_cyc_o drops after 16 REQ cycles; wbs_err_o pulses once; next request proceeds normally.
- Downstream asserts err and ack together -> only wbs_err_o pulses. Upstream drops cyc in REQ -> downstream ack is consumed and no upstream strobe is raised.
- rst pulse during REQ -> all outputs return to reset values immediately; a fresh read afterwards completes correctly.

Source files
------------

// File: rtl/wb_reg_slice.sv
// Registered Wishbone B3 slice: forwards each upstream beat as a classic
// downstream access, registers the response back, and forces an error on a stalled downstream.
module wb_reg_slice #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic                    wbs_rty_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_rty;
  logic [DATA_WIDTH-1:0] r_rdat;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_abort;

  logic                  w_dn_rsp;
  logic                  w_timeout;
  logic                  w_start;
  logic                  w_finish;
  logic                  w_drop;
  logic [2:0]            w_kind;
  logic                  w_unused;

  // Bursts are flattened, so the upstream burst hints are deliberately dropped.
  assign w_unused  = ^{wbs_cti_i, wbs_bte_i};

  assign w_dn_rsp  = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_drop    = r_abort | ~wbs_cyc_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (wbs_cyc_i && wbs_stb_i)  w_state_nxt = S_REQ;
      S_REQ:   if (w_dn_rsp || w_timeout)  w_state_nxt = S_RSP;
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_start  = wbs_cyc_i & wbs_stb_i;
      S_REQ:   w_finish = w_dn_rsp | w_timeout;
      default: ;
    endcase
    // Response kind as {err, rty, ack}; no downstream response here means a timeout.
    if (wbm_err_i || !w_dn_rsp) w_kind = 3'b100;
    else if (wbm_rty_i)         w_kind = 3'b010;
    else                        w_kind = 3'b001;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_rdat  <= '0;
      r_abort <= 1'b0;
    end else begin
      if (w_start) begin
        r_cyc <= 1'b1;
        r_we  <= wbs_we_i;
        r_adr <= wbs_adr_i;
        r_dat <= wbs_dat_i;
        r_sel <= wbs_sel_i;
      end
      if (r_state == S_REQ) begin
        if (!wbs_cyc_i) r_abort <= 1'b1;
        if (w_finish) begin
          r_cyc <= 1'b0;
          if (w_dn_rsp && !r_we) r_rdat <= wbm_dat_i;
          if (!w_drop) {r_err, r_rty, r_ack} <= w_kind;
        end
      end
      if (r_state == S_RSP) begin
        {r_err, r_rty, r_ack} <= 3'b000;
        r_abort               <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_cnt <= '0;
    else if (r_state == S_REQ && !w_finish) r_cnt <= r_cnt + CNT_WIDTH'(1);
    else                                 r_cnt <= '0;
  end

  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbs_rty_o = r_rty;
  assign wbs_dat_o = r_rdat;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign wbm_cti_o = 3'b111;
  assign wbm_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_reg_slice.sv
// Bench for wb_reg_slice: upstream master task, downstream slave model and
// scoreboard queues of expected downstream requests and upstream responses.
module tb_wb_reg_slice;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  localparam int LIMIT = 100;

  localparam int DN_ACK     = 0;
  localparam int DN_ERR     = 1;
  localparam int DN_RTY     = 2;
  localparam int DN_ERR_ACK = 3;
  localparam int DN_RTY_ACK = 4;
  localparam int DN_NONE    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [AW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic [SW-1:0] wbs_sel_i;
  logic [2:0]    wbs_cti_i;
  logic [1:0]    wbs_bte_i;
  logic          wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [DW-1:0] wbs_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic          wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [DW-1:0] wbm_dat_i;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } req_t;

  typedef struct {
    logic [2:0]    kind;
    logic [DW-1:0] dat;
  } rsp_t;

  req_t          req_q[$];
  rsp_t          rsp_q[$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            resp_cnt = 0;
  int            dn_cnt   = 0;
  int            dn_mode  = DN_ACK;
  int            dn_lat   = 0;
  logic [DW-1:0] dn_rdat  = '0;
  logic [DW-1:0] exp_rdat = '0;

  wb_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbs_dat_o(wbs_dat_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected upstream strobe as {err, rty, ack}: err beats rty beats ack; silence times out to err.
  function automatic logic [2:0] kind_of(input int mode);
    case (mode)
      DN_ACK:             return 3'b001;
      DN_RTY, DN_RTY_ACK: return 3'b010;
      default:            return 3'b100;
    endcase
  endfunction

  // One upstream beat; called just after a rising edge, returns just after a rising edge.
  task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input logic [2:0] cti, input bit last,
                      output int lat);
    req_t rq;
    rsp_t rs;
    rq.we = we; rq.adr = adr; rq.dat = dat; rq.sel = sel;
    req_q.push_back(rq);
    if (!we && dn_mode != DN_NONE) exp_rdat = dn_rdat;
    rs.kind = kind_of(dn_mode);
    rs.dat  = exp_rdat;
    rsp_q.push_back(rs);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    wbs_cti_i = cti;  wbs_bte_i = 2'b00;
    lat = 0;
    @(negedge clk);
    while (!(wbs_ack_o || wbs_err_o || wbs_rty_o) && lat < LIMIT) begin
      lat++;
      @(negedge clk);
    end
    check("xfer_in_time", 64'(lat < LIMIT), 64'd1);
    @(posedge clk);
    #1;
    if (last) begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    end
  endtask

  initial begin : downstream
    int   age;
    logic prev_cyc;
    req_t rq;
    age = 0; prev_cyc = 1'b0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o) begin
        age++;
        if (age == 1) begin
          check("dn_cyc_gap", 64'(prev_cyc), 64'd0);
          check("dn_cti", 64'(wbm_cti_o), 64'd7);
          check("dn_bte", 64'(wbm_bte_o), 64'd0);
          check("dn_req_pending", 64'(req_q.size() != 0), 64'd1);
          if (req_q.size() != 0) begin
            rq = req_q.pop_front();
            check("dn_we",  64'(wbm_we_o),  64'(rq.we));
            check("dn_adr", 64'(wbm_adr_o), 64'(rq.adr));
            check("dn_dat", 64'(wbm_dat_o), 64'(rq.dat));
            check("dn_sel", 64'(wbm_sel_o), 64'(rq.sel));
          end
        end
        if (age == dn_lat + 1) begin
          wbm_dat_i = dn_rdat;
          case (dn_mode)
            DN_ACK:     wbm_ack_i = 1'b1;
            DN_ERR:     wbm_err_i = 1'b1;
            DN_RTY:     wbm_rty_i = 1'b1;
            DN_ERR_ACK: begin wbm_err_i = 1'b1; wbm_ack_i = 1'b1; end
            DN_RTY_ACK: begin wbm_rty_i = 1'b1; wbm_ack_i = 1'b1; end
            default:    ;
          endcase
          if (dn_mode != DN_NONE) dn_cnt++;
        end
      end else begin
        age = 0;
      end
      prev_cyc = wbm_cyc_o;
    end
  end

  initial begin : monitor
    rsp_t rs;
    forever begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o || wbs_rty_o) begin
        resp_cnt++;
        check("up_dn_idle", 64'(wbm_cyc_o), 64'd0);
        check("up_rsp_pending", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          rs = rsp_q.pop_front();
          check("up_kind", 64'({wbs_err_o, wbs_rty_o, wbs_ack_o}), 64'(rs.kind));
          check("up_dat", 64'(wbs_dat_o), 64'(rs.dat));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    int r0, d0;
    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_cti_i = '0; wbs_bte_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wbm_cyc", 64'(wbm_cyc_o), 64'd0);
    check("rst_wbm_stb", 64'(wbm_stb_o), 64'd0);
    check("rst_wbm_we",  64'(wbm_we_o),  64'd0);
    check("rst_wbm_adr", 64'(wbm_adr_o), 64'd0);
    check("rst_wbm_cti", 64'(wbm_cti_o), 64'd7);
    check("rst_wbs_rsp", 64'({wbs_err_o, wbs_rty_o, wbs_ack_o}), 64'd0);
    check("rst_wbs_dat", 64'(wbs_dat_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single read, downstream answers two cycles after its strobe.
    dn_mode = DN_ACK; dn_lat = 2; dn_rdat = 32'hDEADBEEF;
    xfer(1'b0, 28'h0000100, '0, 4'hF, 3'b000, 1'b1, lat);
    check("read_lat", 64'(lat), 64'd4);

    // Write; upstream data bus keeps the last read value.
    dn_lat = 1;
    xfer(1'b1, 28'h0000200, 32'h12345678, 4'b0011, 3'b000, 1'b1, lat);
    check("write_lat", 64'(lat), 64'd3);

    // Four-beat incrementing burst flattened into classic accesses.
    dn_lat = 0;
    for (int i = 0; i < 4; i++) begin
      dn_rdat = 32'h1000_0000 + DW'(i);
      xfer(1'b0, 28'h0000400 + AW'(4 * i), '0, 4'hF, (i == 3) ? 3'b111 : 3'b010, i == 3, lat);
      check($sformatf("burst%0d_lat", i), 64'(lat), 64'd2);
    end

    // Silent downstream: forced error after TO request cycles, read data untouched.
    dn_mode = DN_NONE; dn_rdat = 32'hBADBAD00;
    xfer(1'b0, 28'h0000500, '0, 4'hF, 3'b000, 1'b1, lat);
    check("timeout_lat", 64'(lat), 64'(TO + 1));
    dn_mode = DN_ACK;
    xfer(1'b1, 28'h0000504, 32'hCAFEF00D, 4'b1100, 3'b000, 1'b1, lat);
    check("after_timeout_lat", 64'(lat), 64'd2);

    // Simultaneous responses resolve by priority.
    dn_mode = DN_ERR_ACK; dn_rdat = 32'hE0E0E0E0;
    xfer(1'b0, 28'h0000600, '0, 4'hF, 3'b000, 1'b1, lat);
    dn_mode = DN_RTY_ACK; dn_lat = 1;
    xfer(1'b1, 28'h0000604, 32'h0BADCAFE, 4'b0001, 3'b000, 1'b1, lat);
    dn_mode = DN_RTY; dn_rdat = 32'h7777AAAA;
    xfer(1'b0, 28'h0000608, '0, 4'hF, 3'b000, 1'b1, lat);

    // Upstream abandons the cycle while the downstream access is in flight.
    dn_mode = DN_ACK; dn_lat = 3; dn_rdat = 32'hA5A50001;
    req_q.push_back('{we: 1'b0, adr: 28'h0000700, dat: '0, sel: 4'hF});
    r0 = resp_cnt; d0 = dn_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 28'h0000700; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_cti_i = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_dn_done", 64'(dn_cnt - d0), 64'd1);
    check("abort_no_rsp", 64'(resp_cnt - r0), 64'd0);
    dn_lat = 0; dn_rdat = 32'h5EED0001;
    xfer(1'b0, 28'h0000710, '0, 4'hF, 3'b000, 1'b1, lat);
    check("after_abort_lat", 64'(lat), 64'd2);

    // Reset pulse while a request waits on the downstream.
    dn_mode = DN_NONE;
    req_q.push_back('{we: 1'b1, adr: 28'h0000800, dat: 32'h11112222, sel: 4'hF});
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 28'h0000800; wbs_dat_i = 32'h11112222; wbs_sel_i = 4'hF;
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_cyc", 64'(wbm_cyc_o), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_wbm_cyc", 64'(wbm_cyc_o), 64'd0);
    check("midrst_wbm_stb", 64'(wbm_stb_o), 64'd0);
    check("midrst_wbm_we",  64'(wbm_we_o),  64'd0);
    check("midrst_wbm_adr", 64'(wbm_adr_o), 64'd0);
    check("midrst_wbm_cti", 64'(wbm_cti_o), 64'd7);
    check("midrst_wbs_dat", 64'(wbs_dat_o), 64'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rdat = '0;
    dn_mode = DN_ACK; dn_lat = 1; dn_rdat = 32'h600DF00D;
    xfer(1'b0, 28'h0000900, '0, 4'hF, 3'b000, 1'b1, lat);
    check("after_rst_lat", 64'(lat), 64'd3);

    repeat (4) @(posedge clk);
    #1;
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    check("req_q_drained", 64'(req_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
